// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU with two-way arbitration.
package alu_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  // Function selects use the 74181 active-low-data table, so S=1110/M=1 is AND.
  localparam logic [3:0] OP_ADD_S = 4'b1001;
  localparam logic       OP_ADD_M = 1'b0;
  localparam logic [3:0] OP_AND_S = 4'b1110;
  localparam logic       OP_AND_M = 1'b1;

endpackage

// File: rtl/alu74181.sv
// One nibble of 74181-style ALU; f_o[NIB_W] is an active-high carry-out, zero in logic mode.
module alu74181
  import alu_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic [3:0]       s_i,
  input  logic             m_i,
  input  logic             cin_i,
  output logic [NIB_W:0]   f_o
);

  logic [NIB_W-1:0] x, y, an, bn, xl, yl;

  always_comb begin
    // Arithmetic: F = X + Y + cin, e.g. S=1001 gives (A|B)+(A&B) = A+B.
    x  = a_i | (b_i & {NIB_W{s_i[0]}}) | (~b_i & {NIB_W{s_i[1]}});
    y  = (a_i & ~b_i & {NIB_W{s_i[2]}}) | (a_i & b_i & {NIB_W{s_i[3]}});
    an = ~a_i;
    bn = ~b_i;
    xl = an | (bn & {NIB_W{s_i[0]}}) | (~bn & {NIB_W{s_i[1]}});
    yl = (an & ~bn & {NIB_W{s_i[2]}}) | (an & bn & {NIB_W{s_i[3]}});
    if (m_i) begin
      f_o = {1'b0, xl ^ yl};
    end else begin
      f_o = {1'b0, x} + {1'b0, y} + {{NIB_W{1'b0}}, cin_i};
    end
  end

endmodule

// File: rtl/alu_seq_arb.sv
// Two-requester round-robin front end feeding a nibble-serial 74181 datapath.
module alu_seq_arb
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][3:0]        req_s,
  input  logic [1:0]             req_m,
  input  logic [1:0]             req_cin,
  input  logic [1:0][WORD_W-1:0] req_a,
  input  logic [1:0][WORD_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WORD_W-1:0]      rsp_f,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int unsigned NIB   = WORD_W / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t                       state_q;
  logic [IDX_W-1:0]             idx_q;
  logic                         carry_q;
  logic [3:0]                   s_q;
  logic                         m_q, cin_q;
  logic [NIB-1:0][NIB_W-1:0]    a_q, b_q, f_q;
  logic                         cout_q, id_q, last_q;

  logic                         gnt_id, accept, last_nib, alu_cin;
  logic [NIB_W:0]               alu_f;

  always_comb begin
    // Contention goes to the requester not granted last; a lone requester always wins.
    gnt_id    = (&req_valid) ? ~last_q : req_valid[1];
    req_ready = '0;
    if (rst_n && (state_q == StIdle) && (|req_valid)) req_ready[gnt_id] = 1'b1;
    accept    = |(req_valid & req_ready);
    last_nib  = (idx_q == IDX_W'(NIB - 1));
    alu_cin   = (idx_q == '0) ? cin_q : carry_q;
  end

  alu74181 u_alu (
    .a_i   (a_q[idx_q]),
    .b_i   (b_q[idx_q]),
    .s_i   (s_q),
    .m_i   (m_q),
    .cin_i (alu_cin),
    .f_o   (alu_f)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            s_q     <= req_s[gnt_id];
            m_q     <= req_m[gnt_id];
            cin_q   <= req_cin[gnt_id];
            a_q     <= req_a[gnt_id];
            b_q     <= req_b[gnt_id];
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          f_q[idx_q] <= alu_f[NIB_W-1:0];
          carry_q    <= alu_f[NIB_W];
          if (last_nib) begin
            cout_q  <= m_q ? 1'b0 : alu_f[NIB_W];
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StDone: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid = rst_n && (state_q == StDone);
  assign rsp_id    = id_q;
  assign rsp_f     = f_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_seq_arb.sv
// Directed self-checking bench for alu_seq_arb with hand-computed results.
module tb_alu_seq_arb;
  import alu_seq_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_s = '0;
  logic [1:0]        req_m = '0;
  logic [1:0]        req_cin = '0;
  logic [1:0][W-1:0] req_a = '0;
  logic [1:0][W-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_id;
  logic [W-1:0]      rsp_f;
  logic              rsp_cout;
  logic              busy;

  int checks = 0;
  int errors = 0;

  alu_seq_arb #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_s     (req_s),
    .req_m     (req_m),
    .req_cin   (req_cin),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [3:0] s, input logic m, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    req_s[id]     = s;
    req_m[id]     = m;
    req_cin[id]   = cin;
    req_a[id]     = a;
    req_b[id]     = b;
    req_valid[id] = 1'b1;
  endtask

  // Called just after the accepting edge; checks latency, result and return to idle.
  task automatic finish_op(input string tag, input logic id, input logic [W-1:0] f,
                           input logic cout);
    repeat (NIB - 1) tick();
    check({tag, "_early"}, rsp_valid, 1'b0);
    tick();
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_f"}, rsp_f, f);
    check({tag, "_cout"}, rsp_cout, cout);
    check({tag, "_id"}, rsp_id, id);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic single_op(input string tag, input int id, input logic [3:0] s, input logic m,
                           input logic cin, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] f, input logic cout);
    drive(id, s, m, cin, a, b);
    #1;
    check({tag, "_rdy"}, req_ready, (id == 1) ? 2'b10 : 2'b01);
    tick();
    req_valid = '0;
    finish_op(tag, id[0], f, cout);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_f", rsp_f, 16'h0000);
    rst_n = 1'b1;
    tick();

    single_op("add", 0, OP_ADD_S, OP_ADD_M, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
    single_op("ovf", 0, OP_ADD_S, OP_ADD_M, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    single_op("addc", 0, OP_ADD_S, OP_ADD_M, 1'b1, 16'h1234, 16'h1111, 16'h2346, 1'b0);
    single_op("sub", 0, 4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
    single_op("and", 1, OP_AND_S, OP_AND_M, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);

    // Both requesters held valid across four operations.
    drive(0, OP_ADD_S, OP_ADD_M, 1'b0, 16'h0001, 16'h0002);
    drive(1, OP_AND_S, OP_AND_M, 1'b0, 16'hFFFF, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_rdy", i), req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      finish_op($sformatf("rr%0d", i), 1'(i % 2), (i % 2 == 1) ? 16'h00FF : 16'h0003, 1'b0);
    end
    req_valid = '0;

    // Backpressure with requester 1 waiting.
    drive(0, OP_ADD_S, OP_ADD_M, 1'b0, 16'h1111, 16'h2222);
    #1;
    check("bp_rdy", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    drive(1, OP_AND_S, OP_AND_M, 1'b0, 16'h1234, 16'hFFFF);
    repeat (NIB) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_valid", i), rsp_valid, 1'b1);
      check($sformatf("bp%0d_rdy", i), req_ready, 2'b00);
      check($sformatf("bp%0d_f", i), rsp_f, 16'h3333);
      check($sformatf("bp%0d_id", i), rsp_id, 1'b0);
      tick();
    end
    check("bp_cout", rsp_cout, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle", busy, 1'b0);
    check("bp_novalid", rsp_valid, 1'b0);
    check("bp_next_rdy", req_ready, 2'b10);
    req_valid = '0;

    // Reset while running at nibble 2 after a requester-0 grant.
    drive(0, OP_ADD_S, OP_ADD_M, 1'b0, 16'hAAAA, 16'h1111);
    #1;
    check("mr_rdy", req_ready, 2'b01);
    tick();
    req_valid = '0;
    repeat (2) tick();
    check("mr_busy", busy, 1'b1);
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    check("mr_rst_rdy", req_ready, 2'b00);
    tick();
    req_valid = '0;
    check("mr_rst_valid", rsp_valid, 1'b0);
    check("mr_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 1; i++) begin
      tick();
      check($sformatf("mr_norsp%0d", i), rsp_valid, 1'b0);
    end
    drive(0, OP_ADD_S, OP_ADD_M, 1'b0, 16'h0F0F, 16'h0101);
    drive(1, OP_AND_S, OP_AND_M, 1'b0, 16'hFFFF, 16'hFFFF);
    #1;
    check("mr_first_rdy", req_ready, 2'b01);
    tick();
    req_valid = '0;
    finish_op("mr_op", 1'b0, 16'h1010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_arb.md
ALU_SEQ_ARB -- requirements
Module: alu_seq_arb

Interface
REQ-001 SHALL have parameter WORD_W, default 16, operand/result width; legal values are multiples of 4 and at least 4.
REQ-002 SHALL derive NIB = WORD_W/4, the number of nibble passes per operation.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 req_valid  input  [1:0]  per-requester operation request.
REQ-006 req_ready  output  [1:0]  per-requester accept; a handshake occurs when valid and ready are both high at a rising edge.
REQ-007 req_s  input  [1:0][3:0]  per-requester ALU function select.
REQ-008 req_m  input  [1:0]  per-requester mode; 1 = logic, 0 = arithmetic.
REQ-009 req_cin  input  [1:0]  per-requester carry-in to nibble 0.
REQ-010 req_a, req_b  input  [1:0][WORD_W-1:0]  per-requester operands.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  result consumer accept.
REQ-013 rsp_id  output  1  index of the requester that owns the result.
REQ-014 rsp_f  output  WORD_W  result word.
REQ-015 rsp_cout  output  1  final carry-out.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 In IDLE, SHALL assert req_ready for exactly one valid requester, selected by round-robin arbitration; req_ready SHALL be 0 in RUN and DONE.
REQ-019 Arbitration SHALL grant the requester not granted last when both are valid; a lone valid requester SHALL be granted regardless of history.
REQ-020 On handshake, SHALL capture s, m, cin, a, b and the requester id, clear the nibble index to 0, and move to RUN.
REQ-021 In RUN, each cycle SHALL drive the ALU with nibble[idx] of a and b, the captured s and m, and a carry-in equal to the captured cin when idx=0, otherwise the registered carry.
REQ-022 Each RUN cycle SHALL store ALU f[3:0] into rsp_f nibble[idx] and register f[4] as the carry.
REQ-023 When idx=NIB-1, SHALL move to DONE; otherwise SHALL increment idx.
REQ-024 rsp_cout SHALL equal the f[4] of the last nibble in arithmetic mode, and SHALL be 0 in logic mode.
REQ-025 rsp_valid SHALL be high only in DONE; rsp_f, rsp_cout and rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-026 rsp_valid SHALL first be high after the NIB-th rising edge following the accepting edge.
REQ-027 On the edge where rsp_valid and rsp_ready are both high, SHALL return to IDLE; a new accept SHALL be possible on the next edge, giving a minimum of NIB+2 edges per operation.
REQ-028 A requester SHALL hold its inputs stable while valid and not ready; the block SHALL NOT sample them outside the handshake edge.

Reset
REQ-029 When rst_n=0 at a rising edge, SHALL enter IDLE and clear idx, carry, rsp_f, rsp_cout, rsp_id and busy; rsp_valid and req_ready SHALL be 0 while in reset.
REQ-030 SHALL reset the last-grant pointer to 1, so that requester 0 wins the first contention.
REQ-031 A reset in RUN or DONE SHALL discard the operation without producing any response.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the state enum, NIB_W=4, and named opcode constants (OP_ADD: s=1001 m=0; OP_AND: s=1110 m=1).
REQ-033 SHALL instantiate exactly one alu74181 as its nibble datapath; no other sub-module.

Verification
REQ-034 Reset: hold rst_n=0 for 2 edges -> rsp_valid=0, req_ready=0, busy=0, rsp_f=0x0000.
REQ-035 Add, requester 0: a=0x00FF, b=0x0001, cin=0, OP_ADD -> rsp_f=0x0100, rsp_cout=0, rsp_id=0, rsp_valid high 4 edges after accept.
REQ-036 Overflow: a=0xFFFF, b=0x0001, OP_ADD -> rsp_f=0x0000, rsp_cout=1; logic, requester 1: a=0xF0F0, b=0x3C3C, OP_AND -> rsp_f=0x3030, rsp_cout=0, rsp_id=1.
REQ-037 Contention: both requesters valid continuously for 4 operations -> grant order 0,1,0,1.
REQ-038 Backpressure: rsp_ready=0 for 3 cycles in DONE -> outputs stable, req_ready=0 throughout, then one handshake and a return to IDLE.
REQ-039 Reset in RUN (idx=2) -> no rsp_valid, IDLE, and requester 0 granted next under contention.
